// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the handshaked data memory.
// Size codes, FSM states and the size-to-byte-count helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bundle between the load/store unit and data memory.
// The master drives requests; the slave returns a one-cycle response.
interface data_memory_hs_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [ADDR_BUS_WIDTH-1:0] req_addr;
  logic [DATA_BUS_WIDTH-1:0] req_wdata;
  logic                      rsp_valid;
  logic [DATA_BUS_WIDTH-1:0] rsp_rdata;
  logic                      rsp_fault;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_fault
  );
endinterface

// File: rtl/dmem_format.sv
// Big-endian lane formatting: load extension and store byte lanes.
// Lane k / be[k] refer to byte address a+k; raw[31:24] is mem[a].
module dmem_format
  import dmem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [31:0]     raw,
  input  logic [31:0]     wdata,
  output logic [31:0]     ldata,
  output logic [3:0]      be,
  output logic [3:0][7:0] lanes
);

  logic sx;

  assign sx = ~uns & raw[31];

  always_comb begin
    ldata = '0;
    be    = '0;
    lanes = '0;
    unique case (1'b1)
      size == SIZE_BYTE: begin
        ldata    = {{24{sx}}, raw[31:24]};
        be       = 4'b0001;
        lanes[0] = wdata[7:0];
      end
      size == SIZE_HALF: begin
        ldata    = {{16{sx}}, raw[31:16]};
        be       = 4'b0011;
        lanes[0] = wdata[15:8];
        lanes[1] = wdata[7:0];
      end
      size == SIZE_WORD: begin
        ldata = raw;
        be    = 4'b1111;
        lanes = {wdata[7:0], wdata[15:8],
                 wdata[23:16], wdata[31:24]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed big-endian data memory with valid/ready and wait states.
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned half/word accesses.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 0
) (
  input logic             clk,
  input logic             rst_n,
  data_memory_hs_if.slave bus
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam int AW = ADDR_BUS_WIDTH;

  if (DATA_BUS_WIDTH != 32) begin : g_bad_dw
    $error("data_memory_hs: DATA_BUS_WIDTH must be 32");
  end
  if ((MEM_DEPTH % 4) != 0) begin : g_bad_depth
    $error("data_memory_hs: MEM_DEPTH must be a multiple of 4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("data_memory_hs: WAIT_STATES must be 0..15");
  end

  logic [7:0] mem [MEM_DEPTH] = '{default: 8'h00};

  state_t                    state;
  logic [3:0]                cnt;
  logic                      lat_write;
  logic [1:0]                lat_size;
  logic                      lat_uns;
  logic [AW-1:0]             lat_addr;
  logic [DATA_BUS_WIDTH-1:0] lat_wdata;

  logic                      accept;
  logic                      commit;
  logic                      cur_write;
  logic [1:0]                cur_size;
  logic                      cur_uns;
  logic [AW-1:0]             cur_addr;
  logic [DATA_BUS_WIDTH-1:0] cur_wdata;
  logic [2:0]                nb;
  logic [AW-1:0]             ea;
  logic [AW:0]               end_addr;
  logic                      mis;
  logic                      acc_fault;
  logic [IW-1:0]             idx;
  logic [31:0]               raw;
  logic [31:0]               ldata;
  logic [3:0]                be;
  logic [3:0][7:0]           lanes;
  logic [DATA_BUS_WIDTH-1:0] rdata_n;

  assign accept = bus.req_valid & bus.req_ready;

  // Zero wait states commit on the accept edge, so use live fields.
  assign cur_write = (WAIT_STATES == 0) ? bus.req_write    : lat_write;
  assign cur_size  = (WAIT_STATES == 0) ? bus.req_size     : lat_size;
  assign cur_uns   = (WAIT_STATES == 0) ? bus.req_unsigned : lat_uns;
  assign cur_addr  = (WAIT_STATES == 0) ? bus.req_addr     : lat_addr;
  assign cur_wdata = (WAIT_STATES == 0) ? bus.req_wdata    : lat_wdata;

  assign commit = rst_n & ((WAIT_STATES == 0) ? accept
                : (state == ST_WAIT && cnt == 4'd0));

  assign nb = size_bytes(cur_size);

`ifdef DMEM_MISALIGN_FAULT_EN
  assign ea  = cur_addr;
  assign mis = ((cur_size == SIZE_HALF) && cur_addr[0])
             | ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00));
`else
  assign ea  = cur_addr & ~AW'(nb - 3'd1);
  assign mis = 1'b0;
`endif

  assign end_addr  = {1'b0, ea} + (AW+1)'(nb);
  assign acc_fault = (end_addr > (AW+1)'(MEM_DEPTH))
                   | (cur_size == 2'd3) | mis;

  assign idx = ea[IW-1:0];
  assign raw = {mem[idx], mem[idx + IW'(1)],
                mem[idx + IW'(2)], mem[idx + IW'(3)]};

  dmem_format u_format (
    .size  (cur_size),
    .uns   (cur_uns),
    .raw   (raw),
    .wdata (cur_wdata[31:0]),
    .ldata (ldata),
    .be    (be),
    .lanes (lanes)
  );

  assign rdata_n = (acc_fault | cur_write) ? '0 : ldata;

  always_ff @(posedge clk) begin
    if (commit && !acc_fault && cur_write) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx + IW'(k)] <= lanes[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_fault <= 1'b0;
      lat_write     <= 1'b0;
      lat_size      <= 2'd0;
      lat_uns       <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_size  <= bus.req_size;
        lat_uns   <= bus.req_unsigned;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      unique case (state)
        ST_IDLE, ST_RESP: begin
          if (!accept) begin
            state <= ST_IDLE;
          end else if (WAIT_STATES == 0) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rdata_n;
            bus.rsp_fault <= acc_fault;
          end else begin
            state         <= ST_WAIT;
            cnt           <= 4'(WAIT_STATES - 1);
            bus.req_ready <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state         <= ST_RESP;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rdata_n;
            bus.rsp_fault <= acc_fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench: two instances (0 and 3 wait states) vs a byte-array model.
module tb_data_memory_hs;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_hs_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) bus0 ();
  data_memory_hs_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) bus1 ();

  data_memory_hs #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  data_memory_hs #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32),
    .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  byte unsigned mdl[2][DEPTH];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  function automatic int ws(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic logic ready(input int d);
    return (d == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  task automatic set_req(input int d, input logic v, input logic w,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.req_valid = v; bus0.req_write = w; bus0.req_size = sz;
      bus0.req_unsigned = u; bus0.req_addr = a; bus0.req_wdata = wd;
    end else begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_size = sz;
      bus1.req_unsigned = u; bus1.req_addr = a; bus1.req_wdata = wd;
    end
  endtask

  // Reference: plain byte array, big-endian, addresses as integers.
  function automatic void model(input int d, input logic w,
                                input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic f);
    longint nb, ua, ea;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    ua = longint'(a);
    ea = ua;
    f  = (nb == 0);
`ifdef DMEM_MISALIGN_FAULT_EN
    if (nb != 0 && (ua % nb) != 0) f = 1'b1;
`else
    if (nb != 0) ea = ua - (ua % nb);
`endif
    if (ea + nb > DEPTH) f = 1'b1;
    rd = 32'd0;
    if (!f && w) begin
      for (longint i = 0; i < nb; i++)
        mdl[d][int'(ea + i)] = 8'(wd >> (8 * (nb - 1 - i)));
    end else if (!f) begin
      v = 32'd0;
      for (longint i = 0; i < nb; i++)
        v = (v << 8) | 32'(mdl[d][int'(ea + i)]);
      if (!u && nb < 4 && v[int'(8 * nb - 1)])
        v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic issue(input int d, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [31:0] rd;
    logic f;
    exp_t e;
    int k;
    @(negedge clk);
    set_req(d, 1'b1, w, sz, u, a, wd);
    k = 0;
    while (!ready(d) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready(d)) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout dut%0d addr=%h", d, a);
      set_req(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      return;
    end
    model(d, w, sz, u, a, wd, rd, f);
    e.rdata = rd; e.fault = f; e.cyc = cyc + 1 + ws(d);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1 set_req(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    for (int j = 0; j < ws(d); j++) begin
      @(negedge clk);
      n_tests++;
      if (ready(d) !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_wait dut%0d got %b want 0", d, ready(d));
      end
    end
  endtask

  task automatic check_rsp(input int d, input logic v,
                           input logic [31:0] rd, input logic f);
    exp_t e;
    if (v !== 1'b1) return;
    n_tests++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL spurious_rsp dut%0d cyc=%0d", d, cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (cyc != e.cyc) begin
      n_fail++;
      $display("FAIL rsp_latency dut%0d got cyc %0d want %0d", d, cyc, e.cyc);
    end
    n_tests++;
    if (rd !== e.rdata) begin
      n_fail++;
      $display("FAIL rsp_rdata dut%0d got %h want %h", d, rd, e.rdata);
    end
    n_tests++;
    if (f !== e.fault) begin
      n_fail++;
      $display("FAIL rsp_fault dut%0d got %b want %b", d, f, e.fault);
    end
  endtask

  always @(negedge clk) begin
    check_rsp(0, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_fault);
    check_rsp(1, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_fault);
  end

  task automatic chk_reset(input int d);
    logic v, r, f;
    logic [31:0] rd;
    v  = (d == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    r  = ready(d);
    f  = (d == 0) ? bus0.rsp_fault : bus1.rsp_fault;
    rd = (d == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    n_tests += 4;
    if (v !== 1'b0) begin n_fail++; $display("FAIL rst_valid dut%0d got %b want 0", d, v); end
    if (r !== 1'b1) begin n_fail++; $display("FAIL rst_ready dut%0d got %b want 1", d, r); end
    if (f !== 1'b0) begin n_fail++; $display("FAIL rst_fault dut%0d got %b want 0", d, f); end
    if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_rdata dut%0d got %h want 0", d, rd); end
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [31:0] a;
    logic [1:0] sz;
    int r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 15);
      sz = (r == 15) ? 2'd3 : 2'(r % 3);
      a  = $urandom_range(0, DEPTH + 7);
      if ($urandom_range(0, 15) == 0) a = a | (32'h100 << $urandom_range(0, 20));
      issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    int k;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'h00;
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;

    issue(0, 1, SIZE_WORD, 0, 32'd8, 32'hDEADBEEF);
    issue(0, 0, SIZE_WORD, 0, 32'd8, 32'd0);
    issue(0, 0, SIZE_BYTE, 0, 32'd8, 32'd0);
    issue(0, 0, SIZE_BYTE, 1, 32'd8, 32'd0);
    issue(0, 0, SIZE_HALF, 0, 32'd10, 32'd0);
    issue(0, 0, SIZE_HALF, 1, 32'd10, 32'd0);
    issue(0, 1, SIZE_BYTE, 0, 32'd9, 32'h12345655);
    issue(0, 0, SIZE_WORD, 0, 32'd8, 32'd0);
    issue(0, 0, SIZE_WORD, 0, 32'd4, 32'd0);
    issue(0, 0, SIZE_WORD, 0, 32'd12, 32'd0);
    issue(0, 1, SIZE_WORD, 0, 32'd252, 32'h01020304);
    issue(0, 0, SIZE_WORD, 0, DEPTH - 2, 32'd0);
    issue(0, 1, SIZE_WORD, 0, DEPTH - 2, 32'hCAFEBABE);
    issue(0, 0, SIZE_WORD, 0, 32'd252, 32'd0);
    issue(0, 0, SIZE_HALF, 0, DEPTH - 2, 32'd0);
    issue(0, 0, SIZE_WORD, 0, 32'h0A, 32'd0);
    issue(0, 0, SIZE_HALF, 1, 32'h09, 32'd0);
    issue(0, 0, 2'd3, 0, 32'd8, 32'd0);
    issue(0, 0, SIZE_BYTE, 0, 32'h1000_0008, 32'd0);
    rand_ops(0, 200);

    issue(1, 1, SIZE_WORD, 0, 32'd16, 32'hCAFEF00D);
    issue(1, 0, SIZE_WORD, 0, 32'd16, 32'd0);
    issue(1, 0, SIZE_HALF, 0, 32'd18, 32'd0);
    issue(1, 0, SIZE_BYTE, 1, 32'd17, 32'd0);
    issue(1, 1, SIZE_WORD, 0, 32'd32, 32'h11223344);
    rand_ops(1, 40);

    repeat (6) @(negedge clk);
    set_req(1, 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'd32, 32'hA5A5A5A5);
    @(posedge clk);
    #1 set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 0, SIZE_WORD, 0, 32'd32, 32'd0);
    issue(0, 0, SIZE_WORD, 0, 32'd8, 32'd0);

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL missing_rsp got %0d/%0d pending want 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
